// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; the default build gives data fixed priority.
module mem_port_arbiter #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [AWIDTH-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DWIDTH-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic [AWIDTH-1:0]   d_addr_i,
    input  logic                d_we_i,
    input  logic [DWIDTH-1:0]   d_wdata_i,
    input  logic [DWIDTH/8-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DWIDTH-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic [AWIDTH-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DWIDTH-1:0]   mem_wdata_o,
    output logic [DWIDTH/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DWIDTH-1:0]   mem_rdata_i
);

    localparam int BWIDTH = DWIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [BWIDTH-1:0]   be_q, be_d;
    logic [DWIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DWIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                pick_data;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers whether data won the last arbitration; reset leaves data favoured.
    logic last_data_q;

    assign pick_data = d_req_i && !(if_req_i && last_data_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_data_q <= 1'b0;
        end else if (state_q == IDLE && (if_req_i || d_req_i)) begin
            last_data_q <= pick_data;
        end
    end
`else
    assign pick_data = d_req_i;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    owner_d = pick_data;
                    addr_d  = pick_data ? d_addr_i : if_addr_i;
                    we_d    = pick_data && d_we_i;
                    wdata_d = pick_data ? d_wdata_i : '0;
                    be_d    = (pick_data && d_we_i) ? d_be_i : '1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if_gnt_o = !owner_q;
                    d_gnt_o  = owner_q;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (mem_rvalid_i) begin
                    if (owner_q) begin
                        d_rvalid_o = 1'b1;
                        d_rdata_d  = mem_rdata_i;
                    end else begin
                        if_rvalid_o = 1'b1;
                        if_rdata_d  = mem_rdata_i;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload is only presented while requesting so the memory bus idles at zero.
    assign mem_req_o   = (state_q == REQ);
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;
    assign mem_be_o    = mem_req_o ? be_q : '0;

    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : if_rdata_q;
    assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : d_rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule
